// File: rtl/jtframe_pll_lockcen.sv
// PLL lock reset sequencer with fractional CEN_N/CEN_M clock enables.
// Define JTFRAME_LOCKLOSS_CNT_EN to count loss-of-lock events on lost_cnt.
module jtframe_pll_lockcen #(
    parameter int WAIT_W = 16,
    parameter int WAIT   = 5000,
    parameter int CW     = 10,
    parameter int CEN_N  = 1,
    parameter int CEN_M  = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       rst_sys,
    output logic       lock_ok,
    output logic       cen,
    output logic       cen2,
    output logic [7:0] lost_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        COUNT,
        RUN
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT - 1);
    localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);
    localparam logic [CW-1:0]     N_CW      = CW'(CEN_N);
    localparam logic [CW-1:0]     M_CW      = CW'(CEN_M);

    state_t            st;
    state_t            st_nx;
    logic              lk1;
    logic              lk_s;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nx;
    logic [CW-1:0]     acc;
    logic [CW-1:0]     acc_nx;
    logic [CW-1:0]     sum;
    logic              tgl;
    logic              tgl_nx;
    logic              cen_nx;
    logic              cen2_nx;
    logic              run_nx;

    // locked is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            lk1  <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk1  <= locked;
            lk_s <= lk1;
        end
    end

    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        unique case (st)
            WAIT_LOCK: begin
                cnt_nx = '0;
                if (lk_s) st_nx = COUNT;
            end
            COUNT: begin
                if (!lk_s) begin
                    st_nx  = WAIT_LOCK;
                    cnt_nx = '0;
                end else if (cnt == WAIT_LAST) begin
                    st_nx  = RUN;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lk_s) st_nx = WAIT_LOCK;
            end
            default: begin
                st_nx  = WAIT_LOCK;
                cnt_nx = '0;
            end
        endcase
    end

    assign run_nx = (st_nx == RUN);

    // Enables only advance on edges that start and end in RUN
    always_comb begin
        sum     = acc + N_CW;
        acc_nx  = '0;
        tgl_nx  = 1'b0;
        cen_nx  = 1'b0;
        cen2_nx = 1'b0;
        if (st == RUN && run_nx) begin
            if (sum >= M_CW) begin
                acc_nx  = sum - M_CW;
                cen_nx  = 1'b1;
                cen2_nx = !tgl;
                tgl_nx  = !tgl;
            end else begin
                acc_nx  = sum;
                tgl_nx  = tgl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= WAIT_LOCK;
            cnt     <= '0;
            acc     <= '0;
            tgl     <= 1'b0;
            cen     <= 1'b0;
            cen2    <= 1'b0;
            rst_sys <= 1'b1;
            lock_ok <= 1'b0;
        end else begin
            st      <= st_nx;
            cnt     <= cnt_nx;
            acc     <= acc_nx;
            tgl     <= tgl_nx;
            cen     <= cen_nx;
            cen2    <= cen2_nx;
            rst_sys <= !run_nx;
            lock_ok <= run_nx;
        end
    end

`ifdef JTFRAME_LOCKLOSS_CNT_EN
    logic lost_ev;

    assign lost_ev = (st == RUN) && !lk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt <= 8'd0;
        end else if (lost_ev && lost_cnt != 8'hff) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end
`else
    assign lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtframe_pll_lockcen.sv
// Bench for jtframe_pll_lockcen: three ratios (1/8, 3/8, 8/8) against a model.
module tb_jtframe_pll_lockcen;

    localparam int WAIT = 4;
    localparam int M    = 8;
`ifdef JTFRAME_LOCKLOSS_CNT_EN
    localparam int LOST_EN = 1;
`else
    localparam int LOST_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       rs  [3];
    logic       lo  [3];
    logic       ce  [3];
    logic       ce2 [3];
    logic [7:0] lc  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jtframe_pll_lockcen #(
            .WAIT_W (16),
            .WAIT   (WAIT),
            .CW     (10),
            .CEN_N  (g == 0 ? 1 : (g == 1 ? 3 : 8)),
            .CEN_M  (M)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .locked   (locked),
            .rst_sys  (rs[g]),
            .lock_ok  (lo[g]),
            .cen      (ce[g]),
            .cen2     (ce2[g]),
            .lost_cnt (lc[g])
        );
    end

    function automatic int nval(input int g);
        return g == 0 ? 1 : (g == 1 ? 3 : 8);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: count consecutive edges with synchronised lock seen
    int m_s     = 0;
    int m_lost  = 0;
    bit m_lk1   = 1'b0;
    bit m_lks   = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_lk1   <= 1'b0;
            m_lks   <= 1'b0;
            m_s     <= 0;
            m_lost  <= 0;
            m_valid <= 1'b1;
        end else begin
            if (m_lks) begin
                m_s <= m_s + 1;
            end else begin
                m_s <= 0;
                if (m_s >= WAIT + 1 && LOST_EN == 1 && m_lost < 255)
                    m_lost <= m_lost + 1;
            end
            m_lks <= m_lk1;
            m_lk1 <= locked;
        end
    end

    function automatic bit exp_cen(input int n, input int k);
        return k >= 1 && (n * k / M) != (n * (k - 1) / M);
    endfunction

    function automatic bit exp_cen2(input int n, input int k);
        return exp_cen(n, k) && ((n * k / M) % 2 == 1);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            for (int g = 0; g < 3; g++) begin
                automatic bit run = (m_s >= WAIT + 1);
                automatic int k   = m_s - (WAIT + 1);
                automatic int n   = nval(g);
                chk($sformatf("n%0d_rst_sys", n), rs[g], !run);
                chk($sformatf("n%0d_lock_ok", n), lo[g], run);
                chk($sformatf("n%0d_cen", n), ce[g], run && exp_cen(n, k));
                chk($sformatf("n%0d_cen2", n), ce2[g], run && exp_cen2(n, k));
                chk($sformatf("n%0d_lost", n), lc[g], m_lost);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_rst_sys", rs[g], 1);
            chk("rst_lock_ok", lo[g], 0);
            chk("rst_cen", ce[g], 0);
            chk("rst_cen2", ce2[g], 0);
            chk("rst_lost", lc[g], 0);
        end

        // Lock from E0: release after E6, first 1/8 cen after E14
        rst    = 1'b0;
        locked = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            @(negedge clk);
            chk("t1_rst_sys", rs[0], e < 6);
            chk("t1_lock_ok", lo[0], e >= 6);
            chk("t1_cen_n1", ce[0], e == 14 || e == 22 || e == 30);
            chk("t1_cen2_n1", ce2[0], e == 14 || e == 30);
            chk("t1_cen_n3", ce[1], e == 9 || e == 12 || e == 14 ||
                e == 17 || e == 20 || e == 22 || e == 25 ||
                e == 28 || e == 30);
            chk("t1_cen_n8", ce[2], e >= 7);
            chk("t1_cen2_n8", ce2[2], e >= 7 && (e - 7) % 2 == 0);
        end

        // Loss of lock sampled at F0
        locked = 1'b0;
        for (int f = 0; f <= 4; f++) begin
            @(negedge clk);
            chk("t2_rst_sys", rs[0], f >= 2);
            chk("t2_lock_ok", lo[0], f < 2);
            chk("t2_cen_n8", ce[2], f < 2);
            if (f >= 2) chk("t2_lost", lc[0], LOST_EN);
        end

        // One-cycle glitch while counter is 2 restarts the window
        locked = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            @(negedge clk);
            chk("t3_rst_sys", rs[0], e < 10);
            chk("t3_rst_sys_n3", rs[1], e < 10);
            if (e == 2) locked = 1'b0;
            if (e == 3) locked = 1'b1;
        end
        chk("t3_lost", lc[0], LOST_EN);

        // Reset mid-RUN with lock held
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("t4_rst_sys", rs[g], 1);
            chk("t4_lock_ok", lo[g], 0);
            chk("t4_cen", ce[g], 0);
            chk("t4_cen2", ce2[g], 0);
            chk("t4_lost", lc[g], 0);
        end
        rst = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            @(negedge clk);
            chk("t4_release", rs[0], e < 6);
        end

        // Repeated losses to reach saturation
        repeat (257) begin
            locked = 1'b1;
            repeat (8) @(negedge clk);
            locked = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("t5_lost_sat", lc[0], LOST_EN == 1 ? 255 : 0);
        chk("t5_lost_sat_n8", lc[2], LOST_EN == 1 ? 255 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
